// File: rtl/byte_packer_pkg.sv
// Shared constants and helpers for the byte packer.
package byte_packer_pkg;

    localparam int WORD_BYTES_DEFAULT = 4;
    localparam int WORD_BYTES_MIN     = 2;
    localparam int WORD_BYTES_MAX     = 8;

    // Contiguous lane mask with the lowest n_lanes bits set (n_lanes 1..8).
    function automatic logic [7:0] keep_mask(input logic [3:0] n_lanes);
        keep_mask = (8'h01 << n_lanes) - 8'h01;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into little-endian words of WORD_BYTES lanes.
// A word is emitted when it fills up or when a byte marked last arrives;
// the output word is held in a single register with ready/valid backpressure.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int WORD_BYTES = WORD_BYTES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [7:0]              s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [8*WORD_BYTES-1:0] m_data,
    output logic [WORD_BYTES-1:0]   m_keep,
    output logic                    m_last
);

    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int CNT_W  = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORD_BYTES - 1);

    generate
        if (WORD_BYTES < WORD_BYTES_MIN || WORD_BYTES > WORD_BYTES_MAX) begin : g_bad_word_bytes
            $error("byte_packer: WORD_BYTES must lie in 2..8");
        end
    endgenerate

    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [DATA_W-1:0]     acc_r;
    logic [DATA_W-1:0]     acc_nxt_s;
    logic                  m_valid_r;
    logic                  m_valid_nxt_s;
    logic [DATA_W-1:0]     m_data_r;
    logic [DATA_W-1:0]     m_data_nxt_s;
    logic [WORD_BYTES-1:0] m_keep_r;
    logic [WORD_BYTES-1:0] m_keep_nxt_s;
    logic                  m_last_r;
    logic                  m_last_nxt_s;

    logic                  s_ready_s;
    logic                  byte_xfer_s;
    logic                  complete_s;
    logic [DATA_W-1:0]     lane_word_s;
    logic [DATA_W-1:0]     merged_s;

    // The output register can take a new word whenever it is empty or being drained.
    assign s_ready_s   = !m_valid_r || m_ready;
    assign byte_xfer_s = s_valid && s_ready_s;
    assign complete_s  = s_last || (cnt_r == CNT_MAX);
    assign lane_word_s = DATA_W'(s_data) << {cnt_r, 3'b000};
    assign merged_s    = acc_r | lane_word_s;

    // Next-state for the accumulator, fill count and output word register.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        acc_nxt_s     = acc_r;
        m_valid_nxt_s = m_valid_r;
        m_data_nxt_s  = m_data_r;
        m_keep_nxt_s  = m_keep_r;
        m_last_nxt_s  = m_last_r;

        if (m_valid_r && m_ready) begin
            m_valid_nxt_s = 1'b0;
        end else begin
            m_valid_nxt_s = m_valid_r;
        end

        if (byte_xfer_s && complete_s) begin
            // Completing byte: publish the word and start a fresh, zeroed accumulator
            // so that unused lanes of the next short word read as zero.
            m_valid_nxt_s = 1'b1;
            m_data_nxt_s  = merged_s;
            m_keep_nxt_s  = WORD_BYTES'(keep_mask(4'(cnt_r) + 4'd1));
            m_last_nxt_s  = s_last;
            cnt_nxt_s     = {CNT_W{1'b0}};
            acc_nxt_s     = {DATA_W{1'b0}};
        end else if (byte_xfer_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
            acc_nxt_s = merged_s;
        end else begin
            cnt_nxt_s = cnt_r;
            acc_nxt_s = acc_r;
        end
    end

    // State registers; reset drops any partial or pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {DATA_W{1'b0}};
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_W{1'b0}};
            m_keep_r  <= {WORD_BYTES{1'b0}};
            m_last_r  <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            acc_r     <= acc_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            m_data_r  <= m_data_nxt_s;
            m_keep_r  <= m_keep_nxt_s;
            m_last_r  <= m_last_nxt_s;
        end
    end

    assign s_ready = s_ready_s;
    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign m_keep  = m_keep_r;
    assign m_last  = m_last_r;

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios plus a random
// valid/ready soak, checked against a queue-based packet model.
module tb_byte_packer;

    localparam int WB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [7:0]      s_data = 8'h00;
    logic            s_last = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [8*WB-1:0] m_data;
    logic [WB-1:0]   m_keep;
    logic            m_last;

    typedef struct {
        logic [8*WB-1:0] data;
        logic [WB-1:0]   keep;
        logic            last;
    } word_t;

    int         checks = 0;
    int         errors = 0;
    word_t      exp_q[$];
    logic [7:0] part_q[$];
    word_t      got_q[$];
    logic       stall_prev = 1'b0;
    word_t      stall_word;

    byte_packer #(.WORD_BYTES(WB)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: collect accepted bytes; a word is formed when the packet ends or WB bytes gathered.
    function automatic void model_byte(input logic [7:0] d, input logic l);
        word_t w;
        part_q.push_back(d);
        if (l || part_q.size() == WB) begin
            w.data = '0;
            w.keep = '0;
            for (int i = 0; i < part_q.size(); i++) begin
                w.data[8*i +: 8] = part_q[i];
                w.keep[i]        = 1'b1;
            end
            w.last = l;
            exp_q.push_back(w);
            part_q.delete();
        end
    endfunction

    // One clock cycle: drive inputs after the falling edge, check, and predict the rising-edge transfers.
    task automatic tick(input logic sv, input logic [7:0] sd, input logic sl, input logic mr,
                        output logic acc);
        word_t cur;
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        s_last  = sl;
        m_ready = mr;
        #1;
        cur.data = m_data;
        cur.keep = m_keep;
        cur.last = m_last;
        chk("s_ready_rule", s_ready, (!m_valid) || m_ready);
        chk("m_valid_pending", m_valid, exp_q.size() != 0);
        if (stall_prev) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", m_data, stall_word.data);
            chk("stall_keep", m_keep, stall_word.keep);
            chk("stall_last", m_last, stall_word.last);
        end
        if (m_valid === 1'b1 && exp_q.size() != 0) begin
            chk("word_data", m_data, exp_q[0].data);
            chk("word_keep", m_keep, exp_q[0].keep);
            chk("word_last", m_last, exp_q[0].last);
        end
        if (m_valid === 1'b1 && mr) begin
            got_q.push_back(cur);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        stall_prev = (m_valid === 1'b1) && !mr;
        stall_word = cur;
        acc = sv && (s_ready === 1'b1);
        if (acc) model_byte(sd, sl);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic mr);
        logic a;
        int   n;
        n = 0;
        a = 1'b0;
        while (!a && n < 50) begin
            tick(1'b1, d, l, mr, a);
            n++;
        end
        if (!a) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input logic mr);
        logic a;
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, mr, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        part_q.delete();
        got_q.delete();
        stall_prev = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_m_keep", m_keep, 4'h0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_s_ready", s_ready, 1'b1);
    endtask

    // Directed scenarios followed by the random soak.
    initial begin : main
        logic a;
        int   sent;
        int   cyc;
        logic [7:0] d;
        logic l;

        do_reset();

        // Eight bytes, two full words.
        for (int i = 1; i <= 8; i++) send_byte(8'(i), (i == 8), 1'b1);
        idle(2, 1'b1);
        chk("r032_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("r032_w0_data", got_q[0].data, 32'h04030201);
            chk("r032_w0_keep", got_q[0].keep, 4'hF);
            chk("r032_w0_last", got_q[0].last, 1'b0);
            chk("r032_w1_data", got_q[1].data, 32'h08070605);
            chk("r032_w1_keep", got_q[1].keep, 4'hF);
            chk("r032_w1_last", got_q[1].last, 1'b1);
        end
        got_q.delete();

        // Short packet of three bytes.
        send_byte(8'hAA, 1'b0, 1'b1);
        send_byte(8'hBB, 1'b0, 1'b1);
        send_byte(8'hCC, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("r033_count", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            chk("r033_data", got_q[0].data, 32'h00CCBBAA);
            chk("r033_keep", got_q[0].keep, 4'h7);
            chk("r033_last", got_q[0].last, 1'b1);
        end
        got_q.delete();

        // Single-byte packet, emitted on the very next cycle.
        send_byte(8'h5A, 1'b1, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b1, a);
        chk("r034_latency", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            chk("r034_data", got_q[0].data, 32'h0000005A);
            chk("r034_keep", got_q[0].keep, 4'h1);
            chk("r034_last", got_q[0].last, 1'b1);
        end
        idle(1, 1'b1);
        got_q.delete();

        // Backpressure: word held for five cycles, then replaced without a bubble.
        send_byte(8'h33, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'h44, 1'b1, 1'b0, a);
            chk("r035_s_ready_low", s_ready, 1'b0);
            chk("r035_data_held", m_data, 32'h00000033);
        end
        send_byte(8'h44, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("r035_count", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk("r035_w0_data", got_q[0].data, 32'h00000033);
            chk("r035_w1_data", got_q[1].data, 32'h00000044);
        end
        got_q.delete();

        // Reset in the middle of a packet discards the partial word.
        send_byte(8'hE0, 1'b0, 1'b1);
        send_byte(8'hE1, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), (i == 3), 1'b1);
        idle(2, 1'b1);
        chk("r036_count", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            chk("r036_data", got_q[0].data, 32'h14131211);
            chk("r036_keep", got_q[0].keep, 4'hF);
            chk("r036_last", got_q[0].last, 1'b1);
        end
        got_q.delete();

        // Random soak: bytes held until accepted, random valid and ready.
        sent = 0;
        cyc  = 0;
        d    = 8'($urandom);
        l    = ($urandom_range(0, 4) == 0);
        while (sent < 10000 && cyc < 60000) begin
            tick(($urandom_range(0, 3) != 0), d, l, ($urandom_range(0, 3) != 0), a);
            cyc++;
            if (a) begin
                sent++;
                d = 8'($urandom);
                l = ($urandom_range(0, 4) == 0) || (sent == 9999);
            end
        end
        chk("soak_all_sent", sent, 10000);
        idle(4, 1'b1);
        chk("soak_drained", exp_q.size(), 0);
        chk("soak_no_partial", part_q.size(), 0);
        chk("soak_idle_valid", m_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
